// File: rtl/pci_io_initiator.sv
// PCI I/O initiator: takes one local read/write request at a time and runs it
// as a single or burst I/O transaction on the PCI bus. Handles target wait
// states, target disconnect (STOP) and master abort on a missing DEVSEL.
module pci_io_initiator #(
    parameter int          MAX_BURST      = 4,
    parameter int          DEVSEL_TIMEOUT = 5,
    parameter logic [3:0]  CMD_READ       = 4'b0010,
    parameter logic [3:0]  CMD_WRITE      = 4'b0011
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [2:0]   req_len,
    input  logic [127:0] req_wdata,
    input  logic [15:0]  req_be,
    output logic [31:0]  rd_data,
    output logic         rd_valid,
    output logic [1:0]   rd_index,
    output logic         done,
    output logic [1:0]   done_status,
    output logic [2:0]   done_count,
    output logic         FRAMEn,
    output logic         IRDYn,
    inout  wire  [31:0]  AD,
    output logic [3:0]   CBE,
    input  logic         DEVSELn,
    input  logic         TRDYn,
    input  logic         STOP
);

    localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DEVSEL_TIMEOUT - 1);
    localparam logic [2:0]    MAX_LEN  = 3'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RELEASE} state_t;

    state_t         state_reg, state_next;
    logic [127:0]   wdata_reg, wdata_next;
    logic [15:0]    be_reg, be_next;
    logic [2:0]     len_reg, len_next;
    logic           write_reg, write_next;
    logic [1:0]     n_reg, n_next;
    logic [2:0]     count_reg, count_next;
    logic           stop_reg, stop_next;
    logic           abort_reg, abort_next;
    logic           devsel_seen_reg, devsel_seen_next;
    logic [TW-1:0]  devsel_cnt_reg, devsel_cnt_next;
    logic           frame_n_reg, frame_n_next;
    logic           irdy_n_reg, irdy_n_next;
    logic [31:0]    ad_out_reg, ad_out_next;
    logic           ad_oe_reg, ad_oe_next;
    logic [3:0]     cbe_reg, cbe_next;
    logic           req_ready_reg, req_ready_next;
    logic [31:0]    rd_data_reg, rd_data_next;
    logic           rd_valid_reg, rd_valid_next;
    logic [1:0]     rd_index_reg, rd_index_next;
    logic           done_reg, done_next;
    logic [1:0]     status_reg, status_next;
    logic [2:0]     dcount_reg, dcount_next;

    // Per-dword views of the captured write data and byte enables.
    logic [31:0] wdata_dw [MAX_BURST];
    logic [3:0]  be_dw    [MAX_BURST];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_BURST; gi++) begin : g_dw
            assign wdata_dw[gi] = wdata_reg[32*gi +: 32];
            assign be_dw[gi]    = be_reg[4*gi +: 4];
        end
    endgenerate

    logic       xfer, last, go_rel;
    logic [1:0] rel_status;
    logic [2:0] rel_count, count_inc;
    logic [1:0] n_inc;

    // Next-state and next-output logic; every bus output comes from a register.
    always_comb begin
        state_next       = state_reg;
        wdata_next       = wdata_reg;
        be_next          = be_reg;
        len_next         = len_reg;
        write_next       = write_reg;
        n_next           = n_reg;
        count_next       = count_reg;
        stop_next        = stop_reg;
        abort_next       = abort_reg;
        devsel_seen_next = devsel_seen_reg;
        devsel_cnt_next  = devsel_cnt_reg;
        frame_n_next     = frame_n_reg;
        irdy_n_next      = irdy_n_reg;
        ad_out_next      = ad_out_reg;
        ad_oe_next       = ad_oe_reg;
        cbe_next         = cbe_reg;
        req_ready_next   = req_ready_reg;
        rd_data_next     = rd_data_reg;
        rd_valid_next    = 1'b0;
        rd_index_next    = rd_index_reg;
        done_next        = 1'b0;
        status_next      = status_reg;
        dcount_next      = dcount_reg;
        go_rel           = 1'b0;
        rel_status       = 2'b00;
        rel_count        = 3'd0;

        xfer      = !irdy_n_reg && !TRDYn && !DEVSELn;
        last      = ({1'b0, n_reg} == (len_reg - 3'd1));
        n_inc     = n_reg + 2'd1;
        count_inc = (count_reg >= MAX_LEN) ? MAX_LEN : count_reg + 3'd1;

        case (state_reg)
            IDLE: begin
                req_ready_next = 1'b1;
                if (req_valid && req_ready_reg) begin
                    wdata_next       = req_wdata;
                    be_next          = req_be;
                    write_next       = req_write;
                    len_next         = (req_len == 3'd0 || req_len > MAX_LEN) ? 3'd1 : req_len;
                    n_next           = 2'd0;
                    count_next       = 3'd0;
                    stop_next        = 1'b0;
                    abort_next       = 1'b0;
                    devsel_seen_next = 1'b0;
                    devsel_cnt_next  = '0;
                    state_next       = ADDR;
                    req_ready_next   = 1'b0;
                    frame_n_next     = 1'b0;
                    irdy_n_next      = 1'b1;
                    ad_out_next      = req_addr;
                    ad_oe_next       = 1'b1;
                    cbe_next         = req_write ? CMD_WRITE : CMD_READ;
                end
            end
            ADDR: begin
                // Reads release AD here: the first data CLK is the turnaround.
                state_next   = DATA;
                irdy_n_next  = 1'b0;
                ad_out_next  = wdata_dw[0];
                ad_oe_next   = write_reg;
                cbe_next     = be_dw[0];
                frame_n_next = (len_reg == 3'd1);
            end
            DATA: begin
                if (!DEVSELn) devsel_seen_next = 1'b1;
                if (xfer && !write_reg) begin
                    rd_data_next  = AD;
                    rd_valid_next = 1'b1;
                    rd_index_next = n_reg;
                end
                if (abort_reg) begin
                    go_rel = 1'b1; rel_status = 2'b10; rel_count = 3'd0;
                end else if (xfer && last) begin
                    // All data moved wins over a concurrent STOP.
                    go_rel = 1'b1; rel_status = 2'b00; rel_count = count_inc;
                end else if (xfer && (stop_reg || !STOP)) begin
                    go_rel = 1'b1; rel_status = 2'b01; rel_count = count_inc;
                end else if (!STOP && TRDYn) begin
                    go_rel = 1'b1; rel_status = 2'b01; rel_count = count_reg;
                end else begin
                    if (xfer) begin
                        n_next      = n_inc;
                        count_next  = count_inc;
                        ad_out_next = wdata_dw[n_inc];
                        cbe_next    = be_dw[n_inc];
                        if ({1'b0, n_inc} == (len_reg - 3'd1)) frame_n_next = 1'b1;
                    end
                    if (!STOP) begin
                        stop_next    = 1'b1;
                        frame_n_next = 1'b1;
                    end
                    if (!devsel_seen_reg && DEVSELn) begin
                        devsel_cnt_next = devsel_cnt_reg + 1'b1;
                        if (devsel_cnt_reg == TMO_LAST) begin
                            abort_next   = 1'b1;
                            frame_n_next = 1'b1;
                        end
                    end
                end
            end
            RELEASE: begin
                state_next     = IDLE;
                req_ready_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (go_rel) begin
            state_next   = RELEASE;
            frame_n_next = 1'b1;
            irdy_n_next  = 1'b1;
            ad_oe_next   = 1'b0;
            cbe_next     = 4'd0;
            done_next    = 1'b1;
            status_next  = rel_status;
            dcount_next  = rel_count;
            count_next   = rel_count;
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg       <= IDLE;
            wdata_reg       <= '0;
            be_reg          <= '0;
            len_reg         <= 3'd1;
            write_reg       <= 1'b0;
            n_reg           <= 2'd0;
            count_reg       <= 3'd0;
            stop_reg        <= 1'b0;
            abort_reg       <= 1'b0;
            devsel_seen_reg <= 1'b0;
            devsel_cnt_reg  <= '0;
            frame_n_reg     <= 1'b1;
            irdy_n_reg      <= 1'b1;
            ad_out_reg      <= 32'd0;
            ad_oe_reg       <= 1'b0;
            cbe_reg         <= 4'd0;
            req_ready_reg   <= 1'b1;
            rd_data_reg     <= 32'd0;
            rd_valid_reg    <= 1'b0;
            rd_index_reg    <= 2'd0;
            done_reg        <= 1'b0;
            status_reg      <= 2'b00;
            dcount_reg      <= 3'd0;
        end else begin
            state_reg       <= state_next;
            wdata_reg       <= wdata_next;
            be_reg          <= be_next;
            len_reg         <= len_next;
            write_reg       <= write_next;
            n_reg           <= n_next;
            count_reg       <= count_next;
            stop_reg        <= stop_next;
            abort_reg       <= abort_next;
            devsel_seen_reg <= devsel_seen_next;
            devsel_cnt_reg  <= devsel_cnt_next;
            frame_n_reg     <= frame_n_next;
            irdy_n_reg      <= irdy_n_next;
            ad_out_reg      <= ad_out_next;
            ad_oe_reg       <= ad_oe_next;
            cbe_reg         <= cbe_next;
            req_ready_reg   <= req_ready_next;
            rd_data_reg     <= rd_data_next;
            rd_valid_reg    <= rd_valid_next;
            rd_index_reg    <= rd_index_next;
            done_reg        <= done_next;
            status_reg      <= status_next;
            dcount_reg      <= dcount_next;
        end
    end

    assign AD          = ad_oe_reg ? ad_out_reg : 32'bz;
    assign FRAMEn      = frame_n_reg;
    assign IRDYn       = irdy_n_reg;
    assign CBE         = cbe_reg;
    assign req_ready   = req_ready_reg;
    assign rd_data     = rd_data_reg;
    assign rd_valid    = rd_valid_reg;
    assign rd_index    = rd_index_reg;
    assign done        = done_reg;
    assign done_status = status_reg;
    assign done_count  = dcount_reg;

endmodule

// File: tb/tb_pci_io_initiator.sv
// Bench for pci_io_initiator: a small PCI I/O target model (4 dwords at
// 0xFA0..0xFA3) plus a scoreboard of expected read data and completions.
module tb_pci_io_initiator;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_write;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [2:0]   req_len;
    logic [127:0] req_wdata;
    logic [15:0]  req_be;
    logic [31:0]  rd_data;
    logic         rd_valid;
    logic [1:0]   rd_index;
    logic         done;
    logic [1:0]   done_status;
    logic [2:0]   done_count;
    logic         FRAMEn, IRDYn;
    wire  [31:0]  AD;
    logic [3:0]   CBE;
    logic         DEVSELn, TRDYn, STOP;

    pci_io_initiator dut (
        .CLK(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_be(req_be),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index),
        .done(done), .done_status(done_status), .done_count(done_count),
        .FRAMEn(FRAMEn), .IRDYn(IRDYn), .AD(AD), .CBE(CBE),
        .DEVSELn(DEVSELn), .TRDYn(TRDYn), .STOP(STOP)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- target model ----------------
    logic [31:0] mem [4];
    logic [31:0] tgt_ad;
    logic        tgt_ad_en;
    int          tgt_wait, tgt_stop_after;
    assign AD = tgt_ad_en ? tgt_ad : 32'bz;

    task automatic tgt_reset();
        mem[0] = 32'hA0A0B0B0; mem[1] = 32'hC0C0D0D0;
        mem[2] = 32'h00111100; mem[3] = 32'h10101010;
        tgt_wait = 0; tgt_stop_after = 0;
    endtask

    initial begin
        logic        active, twrite, pend_xfer;
        logic [31:0] pend_ad;
        logic [3:0]  pend_be;
        logic [1:0]  idx;
        int          xfer_cnt, wcnt;
        active = 0; twrite = 0; pend_xfer = 0; pend_ad = 0; pend_be = 0;
        idx = 0; xfer_cnt = 0; wcnt = 0;
        DEVSELn = 1; TRDYn = 1; STOP = 1; tgt_ad_en = 0; tgt_ad = 0;
        forever begin
            @(posedge clk); #1;
            if (pend_xfer) begin
                if (twrite)
                    for (int b = 0; b < 4; b++)
                        if (pend_be[b]) mem[idx][8*b +: 8] = pend_ad[8*b +: 8];
                if (idx != 2'd3) idx = idx + 2'd1;
                xfer_cnt++;
                wcnt = tgt_wait;
            end
            if (!active && !FRAMEn && IRDYn) begin
                if (AD >= 32'hFA0 && AD <= 32'hFA3) begin
                    active = 1; twrite = (CBE == 4'b0011);
                    idx = AD[1:0]; xfer_cnt = 0; wcnt = tgt_wait;
                end
                DEVSELn = 1; TRDYn = 1; STOP = 1; tgt_ad_en = 0;
            end else if (active && FRAMEn && IRDYn) begin
                active = 0;
                DEVSELn = 1; TRDYn = 1; STOP = 1; tgt_ad_en = 0;
            end else if (active) begin
                DEVSELn = 0;
                if (tgt_stop_after != 0 && xfer_cnt >= tgt_stop_after) begin
                    STOP = 0; TRDYn = 1;
                end else if (wcnt > 0) begin
                    TRDYn = 1; wcnt--;
                end else begin
                    TRDYn = 0;
                end
                tgt_ad_en = !twrite;
                tgt_ad = mem[idx];
            end
            pend_xfer = active && !IRDYn && !TRDYn && !DEVSELn;
            pend_ad = AD;
            pend_be = CBE;
        end
    end

    // ---------------- scoreboard ----------------
    logic [33:0] rd_q[$];    // {index, data}
    logic [4:0]  done_q[$];  // {status, count}

    initial begin
        logic [33:0] er;
        logic [4:0]  ed;
        forever begin
            @(negedge clk);
            if (!reset && rd_valid) begin
                if (rd_q.size() == 0) check("unexpected_rd_valid", 1, 0);
                else begin
                    er = rd_q.pop_front();
                    check("rd_data", rd_data, er[31:0]);
                    check("rd_index", rd_index, er[33:32]);
                    $display("read  idx=%0d data=%h", rd_index, rd_data);
                end
            end
            if (!reset && done) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    ed = done_q.pop_front();
                    check("done_status", done_status, ed[4:3]);
                    check("done_count", done_count, ed[2:0]);
                    $display("done  status=%0d count=%0d", done_status, done_count);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int          irdy_low, frame_hi;
    logic [31:0] addr_seen;
    logic [3:0]  cbe_seen;

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                           input logic [127:0] wdata, input logic [15:0] be);
        int   guard;
        logic got;
        irdy_low = 0; frame_hi = 0; got = 0; guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        check("req_ready_before_issue", req_ready, 1);
        req_valid = 1; req_write = wr; req_addr = addr; req_len = len;
        req_wdata = wdata; req_be = be;
        @(negedge clk);
        req_valid = 0;
        addr_seen = AD; cbe_seen = CBE;   // address phase
        for (guard = 0; guard < 200 && !got; guard++) begin
            @(negedge clk);
            if (!IRDYn) begin irdy_low++; if (FRAMEn) frame_hi++; end
            if (done) got = 1;
        end
        check("done_seen", got, 1);
    endtask

    initial begin
        int dcnt;
        reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        req_wdata = 0; req_be = 0;
        tgt_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_FRAMEn", FRAMEn, 1);
        check("rst_IRDYn", IRDYn, 1);
        check("rst_ad_released", dut.ad_oe_reg, 0);
        check("rst_CBE", CBE, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", done, 0);
        check("rst_done_status", done_status, 0);
        check("rst_done_count", done_count, 0);
        @(negedge clk); reset = 0;

        // Write 4 dwords, zero-wait target.
        done_q.push_back({2'b00, 3'd4});
        run_txn(1, 32'h00000FA0, 3'd4,
                {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16'hFFFF);
        $display("txn   write4 addr=%h cbe=%h irdy_low=%0d frame_hi=%0d", addr_seen, cbe_seen, irdy_low, frame_hi);
        check("wr4_addr", addr_seen, 32'h00000FA0);
        check("wr4_cmd", cbe_seen, 4'b0011);
        check("wr4_data_clks", irdy_low, 4);
        check("wr4_frame_hi_clks", frame_hi, 1);

        // Read back what was written.
        rd_q.push_back({2'd0, 32'h11111111}); rd_q.push_back({2'd1, 32'h22222222});
        rd_q.push_back({2'd2, 32'h33333333}); rd_q.push_back({2'd3, 32'h44444444});
        done_q.push_back({2'b00, 3'd4});
        run_txn(0, 32'h00000FA0, 3'd4, '0, 16'hFFFF);
        $display("txn   readback4 cbe=%h irdy_low=%0d", cbe_seen, irdy_low);
        check("rd4_cmd", cbe_seen, 4'b0010);
        check("rd4_data_clks", irdy_low, 4);

        // Read of reset contents.
        tgt_reset();
        rd_q.push_back({2'd0, 32'hA0A0B0B0}); rd_q.push_back({2'd1, 32'hC0C0D0D0});
        rd_q.push_back({2'd2, 32'h00111100}); rd_q.push_back({2'd3, 32'h10101010});
        done_q.push_back({2'b00, 3'd4});
        run_txn(0, 32'h00000FA0, 3'd4, '0, 16'hFFFF);
        $display("txn   read4 irdy_low=%0d", irdy_low);

        // Read 2 with 3 wait states before each dword: 4 IRDYn-low CLKs per dword,
        // FRAMEn high for all 4 CLKs of the last dword.
        tgt_wait = 3;
        rd_q.push_back({2'd0, 32'h00111100}); rd_q.push_back({2'd1, 32'h10101010});
        done_q.push_back({2'b00, 3'd2});
        run_txn(0, 32'h00000FA2, 3'd2, '0, 16'hFFFF);
        $display("txn   read2wait irdy_low=%0d frame_hi=%0d", irdy_low, frame_hi);
        check("rdwait_irdy_clks", irdy_low, 8);
        check("rdwait_frame_hi_clks", frame_hi, 4);
        tgt_wait = 0;

        // No target: 5 DEVSEL-timeout data CLKs, then one CLK with FRAMEn high.
        done_q.push_back({2'b10, 3'd0});
        run_txn(1, 32'h00001000, 3'd4, {4{32'hDEADBEEF}}, 16'hFFFF);
        $display("txn   abort irdy_low=%0d frame_hi=%0d", irdy_low, frame_hi);
        check("abort_irdy_clks", irdy_low, 6);
        check("abort_frame_hi_clks", frame_hi, 1);

        // Target disconnect after 2 transfers.
        tgt_reset();
        tgt_stop_after = 2;
        done_q.push_back({2'b01, 3'd2});
        run_txn(1, 32'h00000FA0, 3'd4,
                {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, 16'hFFFF);
        $display("txn   stop irdy_low=%0d frame_hi=%0d", irdy_low, frame_hi);
        check("stop_irdy_clks", irdy_low, 3);
        check("stop_mem0", mem[0], 32'hAAAA0001);
        check("stop_mem1", mem[1], 32'hBBBB0002);
        check("stop_mem2_untouched", mem[2], 32'h00111100);
        tgt_stop_after = 0;

        // len=0 behaves as a single dword.
        rd_q.push_back({2'd0, 32'hAAAA0001});
        done_q.push_back({2'b00, 3'd1});
        run_txn(0, 32'h00000FA0, 3'd0, '0, 16'hFFFF);
        $display("txn   read len0 irdy_low=%0d frame_hi=%0d", irdy_low, frame_hi);
        check("len0_data_clks", irdy_low, 1);
        check("len0_frame_hi_clks", frame_hi, 1);

        // Reset in the middle of a write burst.
        tgt_wait = 5;
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h00000FA0; req_len = 3'd4;
        req_wdata = {4{32'h5A5A5A5A}}; req_be = 16'hFFFF;
        @(negedge clk); req_valid = 0;
        repeat (2) @(negedge clk);
        check("midrst_in_data", IRDYn, 0);
        reset = 1;
        @(posedge clk); #1;
        check("midrst_FRAMEn", FRAMEn, 1);
        check("midrst_IRDYn", IRDYn, 1);
        check("midrst_ad_released", dut.ad_oe_reg, 0);
        check("midrst_req_ready", req_ready, 1);
        $display("txn   reset mid-burst FRAMEn=%0d IRDYn=%0d req_ready=%0d", FRAMEn, IRDYn, req_ready);
        @(negedge clk); reset = 0;
        tgt_wait = 0;
        dcnt = 0;
        repeat (10) begin @(negedge clk); if (done) dcnt++; end
        check("midrst_no_done", dcnt, 0);

        check("rd_queue_drained", rd_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
